// File: rtl/mod10_pkg.sv
// rtl/mod10_pkg.sv - step codes, modulus, FSM state type and mod-10 step helper
package mod10_pkg;

  localparam logic [1:0] STEP_HOLD = 2'b00;
  localparam logic [1:0] STEP_INC1 = 2'b01;
  localparam logic [1:0] STEP_INC2 = 2'b10;
  localparam logic [1:0] STEP_DEC1 = 2'b11;

  localparam int MOD_N = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COOL  = 2'd2
  } state_t;

  // -1 is done as +(MOD_N-1) so one conditional subtract covers every wrap
  function automatic logic [3:0] mod10_next(input logic [3:0] cur, input logic [1:0] code);
    logic [4:0] sum;
    case (code)
      STEP_INC1: sum = {1'b0, cur} + 5'd1;
      STEP_INC2: sum = {1'b0, cur} + 5'd2;
      STEP_DEC1: sum = {1'b0, cur} + 5'(MOD_N - 1);
      default:   sum = {1'b0, cur};
    endcase
    if (sum >= 5'(MOD_N)) begin
      sum = sum - 5'(MOD_N);
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/mod10_shadow.sv
// rtl/mod10_shadow.sv - shadow copy of the mod-10 counter state
module mod10_shadow
  import mod10_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_code,
  output logic [3:0] o_shadow
);

  logic [3:0] r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= 4'd0;
    end else if (i_en) begin
      r_shadow <= mod10_next(r_shadow, i_code);
    end
  end

  assign o_shadow = r_shadow;

endmodule

// File: rtl/mod10_step_arbiter.sv
// rtl/mod10_step_arbiter.sv - round-robin A/B arbiter driving a mod-10 step counter
// Optional shadow-vs-counter self-check enabled by MOD10_SHADOW_CHECK_EN.
module mod10_step_arbiter
  import mod10_pkg::*;
#(
  parameter int COOL_CYCLES = 2,
  parameter int CNT_W       = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_a,
  input  logic [1:0] i_code_a,
  output logic       o_ack_a,
  input  logic       i_req_b,
  input  logic [1:0] i_code_b,
  output logic       o_ack_b,
  output logic [1:0] o_w,
  input  logic [3:0] i_count_in,
  output logic [3:0] o_shadow,
  output logic       o_busy,
  output logic       o_mismatch
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr_b;
  logic             r_gnt_b;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_cool;
  logic             w_grant;
  logic             w_pick_b;
  logic             w_issue;
  logic [3:0]       w_shadow;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pick_b    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_a || i_req_b) begin
          w_grant     = 1'b1;
          w_pick_b    = i_req_b && (!i_req_a || r_ptr_b);
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = (COOL_CYCLES > 0) ? COOL : IDLE;
      COOL: begin
        if (r_cool == CNT_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_cool counts remaining COOL cycles, loaded as ISSUE closes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr_b <= 1'b0;
      r_gnt_b <= 1'b0;
      r_code  <= STEP_HOLD;
      r_cool  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_b <= w_pick_b;
        r_code  <= w_pick_b ? i_code_b : i_code_a;
        r_ptr_b <= !w_pick_b;
      end
      if (r_state == ISSUE) begin
        r_cool <= CNT_W'(COOL_CYCLES);
      end else if (r_state == COOL) begin
        r_cool <= r_cool - CNT_W'(1);
      end
    end
  end

  assign w_issue = (r_state == ISSUE);
  assign o_w     = w_issue ? r_code : STEP_HOLD;
  assign o_ack_a = w_issue && !r_gnt_b;
  assign o_ack_b = w_issue && r_gnt_b;
  assign o_busy  = (r_state != IDLE);

  mod10_shadow u_shadow (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_issue),
    .i_code   (r_code),
    .o_shadow (w_shadow)
  );

  assign o_shadow = w_shadow;

`ifdef MOD10_SHADOW_CHECK_EN
  logic r_mismatch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mismatch <= 1'b0;
    end else if (w_shadow != i_count_in) begin
      r_mismatch <= 1'b1;
    end
  end

  assign o_mismatch = r_mismatch;
`else
  logic w_unused_count_in;
  assign w_unused_count_in = ^i_count_in;
  assign o_mismatch        = 1'b0;
`endif

endmodule
